// File: rtl/pe_os_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_os_drain_pkg
//  Brief    : Shared defaults, clog2 helper and width-generic saturating add
//             for the output-stationary drain PE.
//  Revision : 1.0  initial release
// ============================================================================
package pe_os_drain_pkg;

  localparam int unsigned DEF_A_W   = 9;
  localparam int unsigned DEF_B_W   = 8;
  localparam int unsigned DEF_LANES = 1;
  localparam int unsigned DEF_ACC_W = 32;

  // Widest accumulator the saturating adder can serve
  localparam int unsigned SAT_MAX_W = 64;

  // Ceiling log2, 0 for n <= 1
  function automatic int unsigned clog2_u(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [SAT_MAX_W-1:0] sum;
    logic                 sat;
  } sat_res_t;

  // Signed add clamped to a w-bit two's-complement range; operands arrive
  // sign-extended to SAT_MAX_W, result is valid in its low w bits.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] x,
                                       input logic signed [SAT_MAX_W-1:0] y,
                                       input int unsigned                 w);
    logic signed [SAT_MAX_W:0] s;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sat_res_t                  r;
    s  = {x[SAT_MAX_W-1], x} + {y[SAT_MAX_W-1], y};
    hi = ((SAT_MAX_W+1)'(1) <<< (w - 1)) - (SAT_MAX_W+1)'(1);
    lo = -((SAT_MAX_W+1)'(1) <<< (w - 1));
    if (s > hi) begin
      r.sum = hi[SAT_MAX_W-1:0];
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.sum = lo[SAT_MAX_W-1:0];
      r.sat = 1'b1;
    end else begin
      r.sum = s[SAT_MAX_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_os_drain_dot_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : pe_os_drain_dot_lanes
//  Brief    : Combinational LANES-wide signed dot product, sign-extended to
//             ACC_W. Lane 0 occupies the LSBs of each operand bus.
//  Revision : 1.0  initial release
// ============================================================================
module pe_os_drain_dot_lanes
  import pe_os_drain_pkg::*;
#(
  parameter int unsigned A_W   = DEF_A_W,
  parameter int unsigned B_W   = DEF_B_W,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic        [LANES*A_W-1:0] a,
  input  logic        [LANES*B_W-1:0] b,
  output logic signed [ACC_W-1:0]     prod
);

  localparam int unsigned P_W   = A_W + B_W;
  // Exact width of the lane sum; cannot overflow before the final extension
  localparam int unsigned SUM_W = P_W + clog2_u(LANES);

  logic signed [P_W-1:0]   lane_prod [LANES];
  logic signed [SUM_W-1:0] lane_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_prod[i] = P_W'($signed(a[i*A_W +: A_W])) * P_W'($signed(b[i*B_W +: B_W]));
  end

  // Sum the sign-extended lane products
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SUM_W'(lane_prod[i]);
    end
  end

  assign prod = ACC_W'(lane_sum);

endmodule
`default_nettype wire

// File: rtl/pe_os_drain.sv
`default_nettype none
// ============================================================================
//  Module   : pe_os_drain
//  Brief    : Output-stationary systolic PE with LANES signed MACs per cycle,
//             registered operand forwarding and a double-buffered drain
//             register that shifts results down the column while the next
//             tile accumulates.
//  Config   : PE_ACC_SAT_EN - saturating accumulate with sticky ovf flag;
//             undefined gives wrap-around and ovf tied low.
//  Revision : 1.0  initial release
// ============================================================================
module pe_os_drain
  import pe_os_drain_pkg::*;
#(
  parameter int unsigned A_W   = DEF_A_W,
  parameter int unsigned B_W   = DEF_B_W,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [LANES*A_W-1:0] a_in,
  input  logic                 a_valid_in,
  input  logic [LANES*B_W-1:0] b_in,
  input  logic                 b_valid_in,
  output logic [LANES*A_W-1:0] a_out,
  output logic                 a_valid_out,
  output logic [LANES*B_W-1:0] b_out,
  output logic                 b_valid_out,
  input  logic                 drain_load,
  input  logic                 drain_shift,
  input  logic [ACC_W-1:0]     drain_in,
  output logic [ACC_W-1:0]     drain_out,
  output logic [ACC_W-1:0]     acc,
  output logic                 ovf
);

  logic                    fire;
  logic                    restart;
  logic signed [ACC_W-1:0] prod;
  logic        [ACC_W-1:0] acc_sum;

  assign fire    = a_valid_in & b_valid_in;
  assign restart = drain_load | clear;

  pe_os_drain_dot_lanes #(
    .A_W   (A_W),
    .B_W   (B_W),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_dot (
    .a    (a_in),
    .b    (b_in),
    .prod (prod)
  );

`ifdef PE_ACC_SAT_EN
  sat_res_t sat_res;
  logic     acc_sat;

  // Clamp the running sum to the accumulator range
  always_comb begin
    sat_res = sat_add(SAT_MAX_W'(signed'(acc)), SAT_MAX_W'(prod), ACC_W);
    acc_sum = sat_res.sum[ACC_W-1:0];
    acc_sat = sat_res.sat;
  end

  // Sticky overflow, dropped whenever a new tile starts
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (restart) begin
      ovf <= 1'b0;
    end else if (fire && acc_sat) begin
      ovf <= 1'b1;
    end
  end
`else
  assign acc_sum = acc + prod;
  assign ovf     = 1'b0;
`endif

  // Operand forwarding: unconditional one-cycle pipeline, invalid data included
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out       <= '0;
      b_out       <= '0;
      a_valid_out <= 1'b0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      b_out       <= b_in;
      a_valid_out <= a_valid_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Accumulator: a same-cycle MAC on restart becomes the first term of the new tile
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (restart) begin
      acc <= fire ? prod : '0;
    end else if (fire) begin
      acc <= acc_sum;
    end
  end

  // Drain register captures the pre-update accumulator, otherwise shifts the column
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_out <= '0;
    end else if (drain_load) begin
      drain_out <= acc;
    end else if (drain_shift) begin
      drain_out <= drain_in;
    end
  end

endmodule
`default_nettype wire
